// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper ramp controller.
package stepper_pkg;

   localparam int PERIOD_W_DEF = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_ACCEL   = 3'd2,
      S_CRUISE  = 3'd3,
      S_DECEL   = 3'd4,
      S_RELEASE = 3'd5,
      S_DONE    = 3'd6
   } state_e;

endpackage

// File: rtl/sat_addsub.sv
// Saturating add/subtract: the result is clamped at limit_i and never wraps.
// sub_i=1: y = max(a - b, limit); sub_i=0: y = min(a + b, limit).
module sat_addsub #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] limit_i,
   input  logic         sub_i,
   output logic [W-1:0] y_o
);

   logic [W:0] sum;
   logic [W:0] diff;

   // One extra bit catches carry-out on add and borrow on subtract.
   always_comb begin
      sum  = {1'b0, a_i} + {1'b0, b_i};
      diff = {1'b0, a_i} - {1'b0, b_i};
      y_o  = a_i;
      if (sub_i) begin
         y_o = (diff[W] || (diff[W-1:0] < limit_i)) ? limit_i : diff[W-1:0];
      end else begin
         y_o = (sum[W] || (sum[W-1:0] > limit_i)) ? limit_i : sum[W-1:0];
      end
   end

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal/triangular speed ramp on top of a step generator.
// The host hands over a move; this block drives go/stop and updates the live
// step period one cycle after each step the stepper reports.
// Host handshake: i_start is honoured only in IDLE; o_busy stays high from
// the cycle after acceptance until o_done pulses, and o_done is a one-cycle
// pulse presented together with o_busy=0.
module stepper_ramp_ctrl
   import stepper_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_abort,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_aborted,
   input  logic [23:0]         i_steps,
   input  logic                i_direction,
   input  logic [PERIOD_W-1:0] i_start_period,
   input  logic [PERIOD_W-1:0] i_min_period,
   input  logic [PERIOD_W-1:0] i_period_delta,
   output logic                o_stp_go,
   output logic                o_stp_stop,
   output logic [31:0]         o_stp_steps,
   output logic                o_stp_direction,
   output logic [PERIOD_W-1:0] o_stp_period,
   input  logic                i_stp_busy,
   input  logic [31:0]         i_stp_step_count,
   output logic [2:0]          o_state
);

   state_e              state_q;
   logic [23:0]         steps_q;
   logic                dir_q;
   logic [PERIOD_W-1:0] start_q;
   logic [PERIOD_W-1:0] min_q;
   logic [PERIOD_W-1:0] delta_q;
   logic [PERIOD_W-1:0] period_q;
   logic [31:0]         base_q;
   logic [31:0]         prev_done_q;
   logic [23:0]         accel_q;
   logic                go_q;
   logic                stop_q;
   logic                done_q;
   logic                aborted_q;

   logic [31:0]         done_steps;
   logic [31:0]         remaining;
   logic [31:0]         steps_ext;
   logic [31:0]         accel_ext;
   logic [31:0]         accel_nxt;
   logic                step_evt;
   logic                finished;
   logic                no_ramp;
   logic                sat_sub;
   logic [PERIOD_W-1:0] sat_limit;
   logic [PERIOD_W-1:0] sat_y;

   // Step bookkeeping relative to the count latched at start; modular
   // subtraction keeps it correct across a 32-bit counter wrap.
   always_comb begin
      steps_ext  = {8'h00, steps_q};
      accel_ext  = {8'h00, accel_q};
      accel_nxt  = accel_ext + 32'd1;
      done_steps = i_stp_step_count - base_q;
      remaining  = steps_ext - done_steps;
      step_evt   = (done_steps != prev_done_q);
      finished   = (done_steps >= steps_ext);
      no_ramp    = (min_q == start_q);
      sat_sub    = (state_q == S_ACCEL);
      sat_limit  = sat_sub ? min_q : start_q;
   end

   sat_addsub #(.W(PERIOD_W)) u_sat (
      .a_i     (period_q),
      .b_i     (delta_q),
      .limit_i (sat_limit),
      .sub_i   (sat_sub),
      .y_o     (sat_y)
   );

   // Move sequencer with registered outputs; abort outranks completion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         steps_q     <= '0;
         dir_q       <= 1'b0;
         start_q     <= '0;
         min_q       <= '0;
         delta_q     <= '0;
         period_q    <= '0;
         base_q      <= '0;
         prev_done_q <= '0;
         accel_q     <= '0;
         go_q        <= 1'b0;
         stop_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         prev_done_q <= done_steps;
         stop_q      <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  steps_q     <= i_steps;
                  dir_q       <= i_direction;
                  start_q     <= i_start_period;
                  delta_q     <= i_period_delta;
                  // A floor at or above the start speed, or no step change,
                  // collapses the ramp into a flat cruise.
                  min_q       <= ((i_min_period >= i_start_period) || (i_period_delta == '0))
                                 ? i_start_period : i_min_period;
                  base_q      <= i_stp_step_count;
                  prev_done_q <= 32'd0;
                  period_q    <= i_start_period;
                  accel_q     <= '0;
                  aborted_q   <= 1'b0;
                  if (i_steps == 24'd0) begin
                     state_q <= S_DONE;
                  end else begin
                     go_q    <= 1'b1;
                     state_q <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH, S_ACCEL, S_CRUISE, S_DECEL: begin
               if (i_abort) begin
                  stop_q    <= 1'b1;
                  go_q      <= 1'b0;
                  aborted_q <= 1'b1;
                  state_q   <= S_RELEASE;
               end else if (finished) begin
                  go_q    <= 1'b0;
                  state_q <= S_RELEASE;
               end else begin
                  case (state_q)
                     S_LAUNCH: state_q <= no_ramp ? S_CRUISE : S_ACCEL;
                     S_ACCEL: begin
                        if (step_evt) begin
                           period_q <= sat_y;
                           accel_q  <= accel_q + 24'd1;
                           if (remaining <= accel_nxt) begin
                              state_q <= S_DECEL;
                           end else if (sat_y == min_q) begin
                              state_q <= S_CRUISE;
                           end
                        end
                     end
                     S_CRUISE: begin
                        if (remaining <= accel_ext) begin
                           state_q <= S_DECEL;
                        end
                     end
                     S_DECEL: begin
                        if (step_evt) begin
                           period_q <= sat_y;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RELEASE: begin
               if (!i_stp_busy) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_busy          = (state_q != S_IDLE);
   assign o_done          = done_q;
   assign o_aborted       = aborted_q;
   assign o_stp_go        = go_q;
   assign o_stp_stop      = stop_q;
   assign o_stp_steps     = {steps_q, 8'h00};
   assign o_stp_direction = dir_q;
   assign o_stp_period    = period_q;
   assign o_state         = state_q;

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Bench for stepper_ramp_ctrl: a stepper model answers o_stp_go with a step
// every 4 cycles; expected step periods and done records are queued when a
// move is issued and popped by an independent monitor.
module tb_stepper_ramp_ctrl;
   import stepper_pkg::*;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_abort;
   logic        o_busy;
   logic        o_done;
   logic        o_aborted;
   logic [23:0] i_steps;
   logic        i_direction;
   logic [31:0] i_start_period;
   logic [31:0] i_min_period;
   logic [31:0] i_period_delta;
   logic        o_stp_go;
   logic        o_stp_stop;
   logic [31:0] o_stp_steps;
   logic        o_stp_direction;
   logic [31:0] o_stp_period;
   logic        i_stp_busy;
   logic [31:0] i_stp_step_count;
   logic [2:0]  o_state;

   stepper_ramp_ctrl #(.PERIOD_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_aborted        (o_aborted),
      .i_steps          (i_steps),
      .i_direction      (i_direction),
      .i_start_period   (i_start_period),
      .i_min_period     (i_min_period),
      .i_period_delta   (i_period_delta),
      .o_stp_go         (o_stp_go),
      .o_stp_stop       (o_stp_stop),
      .o_stp_steps      (o_stp_steps),
      .o_stp_direction  (o_stp_direction),
      .o_stp_period     (o_stp_period),
      .i_stp_busy       (i_stp_busy),
      .i_stp_step_count (i_stp_step_count),
      .o_state          (o_state)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_period_q[$];
   logic [0:0]  exp_done_q[$];

   int          done_cnt = 0;
   int          done_snap = 0;
   logic        go_ever = 1'b0;
   logic        cruise_seen = 1'b0;
   int          preset_seq = 0;
   logic [31:0] preset_val = '0;
   logic [31:0] base_v;

   logic [31:0] prof_trap [10] = '{100, 90, 80, 70, 60, 60, 60, 70, 80, 90};
   logic [31:0] prof_tri  [4]  = '{100, 70, 40, 70};

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- stepper model (drives stepper-side inputs) ----------------
   initial begin : stepper_model
      int tick;
      int tail;
      int seen_seq;
      tick = 0;
      tail = 0;
      seen_seq = 0;
      i_stp_busy = 1'b0;
      i_stp_step_count = 32'h0000_1000;
      forever begin
         @(negedge clk);
         if (preset_seq != seen_seq) begin
            seen_seq = preset_seq;
            i_stp_step_count = preset_val;
         end
         if (o_stp_go) begin
            i_stp_busy = 1'b1;
            tail = 0;
            tick++;
            if (tick == 4) begin
               tick = 0;
               i_stp_step_count = i_stp_step_count + 32'd1;
            end
         end else begin
            tick = 0;
            if (i_stp_busy) begin
               tail++;
               if (tail == 3) begin
                  tail = 0;
                  i_stp_busy = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [31:0] last_cnt;
      logic [31:0] exp_p;
      logic [0:0]  exp_a;
      last_cnt = '0;
      forever begin
         @(negedge clk);
         #1;
         if (i_stp_step_count != last_cnt) begin
            if (o_stp_go) begin
               if (exp_period_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL step_period: step taken at period %0d with nothing expected", o_stp_period);
               end else begin
                  exp_p = exp_period_q.pop_front();
                  check("step_period", o_stp_period, exp_p);
               end
            end
            last_cnt = i_stp_step_count;
         end
         if (o_stp_go) go_ever = 1'b1;
         if (o_state == S_CRUISE) cruise_seen = 1'b1;
         if (o_done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: o_done=1 expected no completion");
            end else begin
               exp_a = exp_done_q.pop_front();
               check("done_aborted", o_aborted, exp_a);
               check("done_busy_low", o_busy, 1'b0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_move(input logic [23:0] st, input logic dir,
                             input logic [31:0] sp, input logic [31:0] mp, input logic [31:0] dl);
      i_steps        = st;
      i_direction    = dir;
      i_start_period = sp;
      i_min_period   = mp;
      i_period_delta = dl;
      base_v         = i_stp_step_count;
      done_snap      = done_cnt;
      i_start        = 1'b1;
      @(negedge clk);
      #2;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_cnt == done_snap && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      tests++;
      if (done_cnt == done_snap) begin
         fails++;
         $display("FAIL %s: o_done=0 after 3000 cycles, required a done pulse", name);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #2;
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin : main
      int n;
      rst = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_steps = '0;
      i_direction = 1'b0;
      i_start_period = '0;
      i_min_period = '0;
      i_period_delta = '0;
      wait_cycles(3);

      // Reset state
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_go", o_stp_go, 1'b0);
      check("rst_period", o_stp_period, 32'd0);
      check("rst_state", o_state, S_IDLE);
      rst = 1'b1;
      wait_cycles(2);

      // Abort in IDLE is ignored
      i_abort = 1'b1;
      wait_cycles(1);
      i_abort = 1'b0;
      check("idle_abort_stop", o_stp_stop, 1'b0);
      check("idle_abort_flag", o_aborted, 1'b0);
      check("idle_abort_busy", o_busy, 1'b0);

      // Trapezoid: 10 steps, 100 -> 60 by 10
      foreach (prof_trap[k]) exp_period_q.push_back(prof_trap[k]);
      exp_done_q.push_back(1'b0);
      start_move(24'd10, 1'b1, 32'd100, 32'd60, 32'd10);
      check("trap_busy", o_busy, 1'b1);
      check("trap_go", o_stp_go, 1'b1);
      wait_cycles(6);
      i_steps = 24'd99;
      i_direction = 1'b0;
      i_start = 1'b1;
      wait_cycles(1);
      i_start = 1'b0;
      check("busy_start_steps", o_stp_steps, {24'd10, 8'h00});
      check("busy_start_dir", o_stp_direction, 1'b1);
      wait_done("trap_done");
      check("trap_step_total", i_stp_step_count - base_v, 32'd10);
      check("trap_go_low", o_stp_go, 1'b0);

      // Triangle: 4 steps, never cruises
      wait_cycles(2);
      cruise_seen = 1'b0;
      foreach (prof_tri[k]) exp_period_q.push_back(prof_tri[k]);
      exp_done_q.push_back(1'b0);
      start_move(24'd4, 1'b0, 32'd100, 32'd10, 32'd30);
      wait_done("tri_done");
      check("tri_no_cruise", cruise_seen, 1'b0);

      // Zero steps: done two cycles after start, go never raised
      wait_cycles(2);
      go_ever = 1'b0;
      exp_done_q.push_back(1'b0);
      start_move(24'd0, 1'b0, 32'd100, 32'd60, 32'd10);
      check("zero_done_early", o_done, 1'b0);
      check("zero_busy", o_busy, 1'b1);
      wait_cycles(1);
      check("zero_done_latency", o_done, 1'b1);
      wait_cycles(1);
      check("zero_done_width", o_done, 1'b0);
      check("zero_no_go", go_ever, 1'b0);

      // Step counter wraps during the move; flat profile (min >= start)
      preset_val = 32'hFFFF_FFFE;
      preset_seq++;
      wait_cycles(2);
      for (int k = 0; k < 5; k++) exp_period_q.push_back(32'd50);
      exp_done_q.push_back(1'b0);
      start_move(24'd5, 1'b1, 32'd50, 32'd80, 32'd5);
      wait_done("wrap_done");
      check("wrap_count", i_stp_step_count, 32'h0000_0003);

      // Abort mid-cruise after 5 steps
      wait_cycles(2);
      for (int k = 0; k < 5; k++) exp_period_q.push_back(prof_trap[k]);
      exp_done_q.push_back(1'b1);
      start_move(24'd10, 1'b1, 32'd100, 32'd60, 32'd10);
      n = 0;
      while (i_stp_step_count != base_v + 32'd5 && n < 500) begin
         wait_cycles(1);
         n++;
      end
      check("abort_reach_5", i_stp_step_count - base_v, 32'd5);
      check("abort_in_cruise", o_state, S_CRUISE);
      i_abort = 1'b1;
      wait_cycles(1);
      i_abort = 1'b0;
      check("abort_stop", o_stp_stop, 1'b1);
      check("abort_go", o_stp_go, 1'b0);
      check("abort_flag", o_aborted, 1'b1);
      check("abort_busy", o_busy, 1'b1);
      wait_cycles(1);
      check("abort_stop_width", o_stp_stop, 1'b0);
      wait_done("abort_done");

      // Aborted flag holds in IDLE and clears on the next accepted start
      wait_cycles(2);
      check("aborted_held", o_aborted, 1'b1);
      foreach (prof_tri[k]) exp_period_q.push_back(prof_tri[k]);
      exp_done_q.push_back(1'b0);
      start_move(24'd4, 1'b0, 32'd100, 32'd10, 32'd30);
      check("aborted_cleared", o_aborted, 1'b0);
      wait_done("tri2_done");

      // Reset during DECEL, then a normal move
      wait_cycles(2);
      foreach (prof_trap[k]) exp_period_q.push_back(prof_trap[k]);
      start_move(24'd10, 1'b1, 32'd100, 32'd60, 32'd10);
      n = 0;
      while (o_state != S_DECEL && n < 500) begin
         wait_cycles(1);
         n++;
      end
      check("rst_mid_in_decel", o_state, S_DECEL);
      rst = 1'b0;
      wait_cycles(1);
      check("rst_mid_state", o_state, S_IDLE);
      check("rst_mid_busy", o_busy, 1'b0);
      check("rst_mid_go", o_stp_go, 1'b0);
      check("rst_mid_period", o_stp_period, 32'd0);
      check("rst_mid_steps", o_stp_steps, 32'd0);
      check("rst_mid_dir", o_stp_direction, 1'b0);
      check("rst_mid_left", exp_period_q.size(), 4);
      exp_period_q.delete();
      rst = 1'b1;
      wait_cycles(6);
      foreach (prof_tri[k]) exp_period_q.push_back(prof_tri[k]);
      exp_done_q.push_back(1'b0);
      start_move(24'd4, 1'b1, 32'd100, 32'd10, 32'd30);
      wait_done("post_rst_done");
      check("post_rst_steps", i_stp_step_count - base_v, 32'd4);

      wait_cycles(4);
      check("period_q_empty", exp_period_q.size(), 0);
      check("done_q_empty", exp_done_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stepper_ramp_ctrl.md
STEPPER_RAMP_CTRL -- requirements
Module: stepper_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_W, default 32: width of all period/delta values.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have host-side ports:
- i_start  in  1  move request
- i_abort  in  1  abort request
- o_busy  out  1  move in progress
- o_done  out  1  1-cycle completion pulse
- o_aborted  out  1  last move was aborted
REQ-004 SHALL have move-parameter ports:
- i_steps  in  24  full steps
- i_direction  in  1  direction
- i_start_period  in  PERIOD_W  clocks per step at start/stop
- i_min_period  in  PERIOD_W  cruise clocks per step
- i_period_delta  in  PERIOD_W  per-step period change
REQ-005 SHALL have stepper-side ports:
- o_stp_go  out  1  go
- o_stp_stop  out  1  stop
- o_stp_steps  out  32  {i_steps, 8'h00}
- o_stp_direction  out  1  direction
- o_stp_period  out  PERIOD_W  live step period
- i_stp_busy  in  1  stepper busy
- i_stp_step_count  in  32  free-running step count

Function
REQ-006 SHALL implement states IDLE, LAUNCH, ACCEL, CRUISE, DECEL, RELEASE, DONE.
REQ-007 IDLE: i_start=1 SHALL latch all move parameters, latch base=i_stp_step_count, set period=i_start_period and go to LAUNCH; i_start while not IDLE SHALL be ignored.
REQ-008 i_steps=0 at start SHALL go directly to DONE without asserting o_stp_go.
REQ-009 If latched min_period >= start_period or delta=0, min_period SHALL be treated as start_period (no ramp).
REQ-010 LAUNCH: SHALL assert o_stp_go and enter ACCEL (or CRUISE per REQ-009); o_stp_go SHALL stay high through ACCEL, CRUISE and DECEL.
REQ-011 done_steps SHALL equal i_stp_step_count - base (32-bit modular, wrap-safe); remaining = steps - done_steps.
REQ-012 A step event SHALL be a cycle where done_steps differs from its registered previous value; o_stp_period SHALL update exactly one cycle after the event.
REQ-013 ACCEL, on each event: period <= max(period - delta, min_period), saturating at min_period with no underflow; accel_steps += 1.
REQ-014 ACCEL -> CRUISE when the updated period equals min_period; ACCEL or CRUISE -> DECEL when remaining <= accel_steps (triangle profile allowed).
REQ-015 DECEL, on each event: period <= min(period + delta, start_period), saturating with no overflow.
REQ-016 When done_steps >= steps in any motion state, SHALL deassert o_stp_go and enter RELEASE.
REQ-017 RELEASE: SHALL wait for i_stp_busy=0, then enter DONE.
REQ-018 DONE: SHALL pulse o_done for one cycle, then return to IDLE.
REQ-019 o_busy SHALL be 1 in every state except IDLE.
REQ-020 i_abort in LAUNCH/ACCEL/CRUISE/DECEL SHALL pulse o_stp_stop for one cycle, deassert o_stp_go, set o_aborted, and enter RELEASE; i_abort in IDLE/DONE SHALL be ignored.
REQ-021 o_aborted SHALL be cleared on the next accepted i_start.
REQ-022 Simultaneous abort and final step event: abort SHALL take priority.
REQ-023 o_stp_steps and o_stp_direction SHALL be driven from latched values, stable for the whole move.

Reset
REQ-024 rst=0 at a clock edge SHALL force IDLE with all outputs 0, including o_stp_period, accel_steps and base; this applies mid-move.

Structure
REQ-025 State encodings and PERIOD_W default SHALL live in a shared package, stepper_pkg.
REQ-026 Saturating add/subtract SHALL be one sub-module, sat_addsub, instanced for the period update; no other sub-modules.

Verification
REQ-027 steps=10, start=100, min=60, delta=10 -> periods 100,90,80,70,60,60,60,70,80,90; o_done pulses once after busy falls.
REQ-028 steps=4, start=100, min=10, delta=30 -> triangle 100,70,40,70; never reaches CRUISE.
REQ-029 steps=0 -> o_done 2 cycles after i_start; o_stp_go never asserted.
REQ-030 i_abort mid-CRUISE -> o_stp_stop 1 cycle, o_stp_go low next cycle, o_aborted=1, o_done after i_stp_busy=0.
REQ-031 base=32'hFFFF_FFFE, steps=5 -> completes after exactly 5 stepper counts (wrap).
REQ-032 rst=0 during DECEL -> next cycle IDLE, all outputs 0; a new i_start then runs normally.
